// File: rtl/regfile_sweep_if.sv
// Register-file port bundle: one write port, two read ports and the clear handshake.
// Latency: n/a (wires only). Backpressure: none; clr_busy tells the master when writes are dropped.
// master drives addresses/data/clr_req; slave returns read data and sweep status.
interface regfile_sweep_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;

    modport master (
        output we, waddr, wdata, raddr1, raddr2, clr_req,
        input  rdata1, rdata2, clr_busy, clr_done
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2, clr_req,
        output rdata1, rdata2, clr_busy, clr_done
    );
endinterface

// File: rtl/regfile_sweep.sv
// 2R/1W register file cleared by a one-entry-per-cycle sweep FSM; REGFILE_BYPASS_EN adds write-first read forwarding.
// Latency: reads combinational, writes visible next cycle; a clear takes DEPTH cycles.
// Backpressure: none; while clr_busy is high, writes and clr_req are dropped and reads return 0.
module regfile_sweep #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    regfile_sweep_if.slave rf
);
    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nxt;
    logic              clr_busy_q;
    logic              busy_nxt;
    logic              clr_done_q;
    logic              done_nxt;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dat;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_zero_blk;
    logic              fwd_ok;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    assign wr_zero_blk = ZERO_REG && (rf.waddr == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            ptr        <= '0;
            clr_busy_q <= 1'b1;
            clr_done_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            clr_busy_q <= busy_nxt;
            clr_done_q <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        busy_nxt  = clr_busy_q;
        done_nxt  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = rf.waddr;
        mem_dat   = rf.wdata;
        case (state)
            IDLE: begin
                // A clear request in the same cycle as a write wins; the write is lost.
                if (rf.clr_req) begin
                    state_nxt = CLEAR;
                    ptr_nxt   = '0;
                    busy_nxt  = 1'b1;
                end else if (rf.we && !wr_zero_blk) begin
                    mem_we = 1'b1;
                end
            end
            CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = ptr;
                mem_dat  = '0;
                ptr_nxt  = ptr + 1'b1;
                if (ptr == PTR_LAST) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = CLEAR;
                ptr_nxt   = '0;
                busy_nxt  = 1'b1;
            end
        endcase
    end

    // No reset on the array so it can map onto RAM; rst only restarts the sweep.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_addr] <= mem_dat;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign fwd_ok = (state == IDLE) && rf.we && !wr_zero_blk;
`else
    assign fwd_ok = 1'b0;
`endif

    // Mid-sweep the array holds a mix of old and cleared entries, so reads are forced to 0.
    always_comb begin
        rd1 = mem[rf.raddr1];
        if ((state == CLEAR) || (ZERO_REG && (rf.raddr1 == '0))) begin
            rd1 = '0;
        end else if (fwd_ok && (rf.raddr1 == rf.waddr)) begin
            rd1 = rf.wdata;
        end
    end

    always_comb begin
        rd2 = mem[rf.raddr2];
        if ((state == CLEAR) || (ZERO_REG && (rf.raddr2 == '0))) begin
            rd2 = '0;
        end else if (fwd_ok && (rf.raddr2 == rf.waddr)) begin
            rd2 = rf.wdata;
        end
    end

    assign rf.rdata1   = rd1;
    assign rf.rdata2   = rd2;
    assign rf.clr_busy = clr_busy_q;
    assign rf.clr_done = clr_done_q;

    a_busy_tracks_state: assert property (@(posedge clk) clr_busy_q == (state == CLEAR));
    a_done_single:       assert property (@(posedge clk) disable iff (rst) clr_done_q |=> !clr_done_q);
    a_done_not_busy:     assert property (@(posedge clk) clr_done_q |-> !clr_busy_q);

endmodule

// File: tb/tb_regfile_sweep.sv
// Bench for regfile_sweep: a 32x32 zero-reg instance and an 8x8 ordinary-entry-0 instance,
// checked every cycle against an array/countdown model plus hand-computed literal expectations.
module tb_regfile_sweep;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_sweep_if #(.DATA_W(32), .ADDR_W(5)) a ();
    regfile_sweep_if #(.DATA_W(8),  .ADDR_W(3)) b ();

    regfile_sweep #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut_a (.clk(clk), .rst(rst_a), .rf(a));
    regfile_sweep #(.DATA_W(8),  .ADDR_W(3), .ZERO_REG(1'b0)) dut_b (.clk(clk), .rst(rst_b), .rf(b));

    // Model: rem = sweep cycles left (0 = idle); the whole array reads as zero once a sweep ends.
    int          rem    [2] = '{0, 0};
    bit          done_m [2] = '{0, 0};
    bit          valid  [2] = '{0, 0};
    int          depth  [2] = '{32, 8};
    bit          zr     [2] = '{1'b1, 1'b0};
    logic [31:0] m      [2][32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input bit r, input bit we, input int wa,
                              input logic [31:0] wd, input bit clr);
        if (r) begin
            rem[k]    = depth[k];
            done_m[k] = 1'b0;
            valid[k]  = 1'b1;
        end else if (rem[k] > 0) begin
            rem[k]    = rem[k] - 1;
            done_m[k] = (rem[k] == 0);
            if (rem[k] == 0) begin
                for (int i = 0; i < depth[k]; i++) m[k][i] = '0;
            end
        end else begin
            done_m[k] = 1'b0;
            if (clr) rem[k] = depth[k];
            else if (we && !(zr[k] && wa == 0)) m[k][wa] = wd;
        end
    endtask

    function automatic logic [31:0] exp_rd(input int k, input int ra, input bit we,
                                           input int wa, input logic [31:0] wd);
        bit fwd;
        fwd = 1'b0;
`ifdef REGFILE_BYPASS_EN
        fwd = 1'b1;
`endif
        if (rem[k] > 0) return '0;
        if (zr[k] && ra == 0) return '0;
        if (fwd && we && ra == wa) return wd;
        return m[k][ra];
    endfunction

    always @(posedge clk) begin
        model_step(0, rst_a, a.we, int'(a.waddr), a.wdata, a.clr_req);
        model_step(1, rst_b, b.we, int'(b.waddr), 32'(b.wdata), b.clr_req);
    end

    always @(negedge clk) begin
        if (valid[0]) begin
            chk("a.clr_busy", 32'(a.clr_busy), 32'(rem[0] > 0));
            chk("a.clr_done", 32'(a.clr_done), 32'(done_m[0]));
            chk("a.rdata1", a.rdata1, exp_rd(0, int'(a.raddr1), a.we, int'(a.waddr), a.wdata));
            chk("a.rdata2", a.rdata2, exp_rd(0, int'(a.raddr2), a.we, int'(a.waddr), a.wdata));
        end
        if (valid[1]) begin
            chk("b.clr_busy", 32'(b.clr_busy), 32'(rem[1] > 0));
            chk("b.clr_done", 32'(b.clr_done), 32'(done_m[1]));
            chk("b.rdata1", 32'(b.rdata1), exp_rd(1, int'(b.raddr1), b.we, int'(b.waddr), 32'(b.wdata)));
            chk("b.rdata2", 32'(b.rdata2), exp_rd(1, int'(b.raddr2), b.we, int'(b.waddr), 32'(b.wdata)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles from the caller's edge to the clr_done pulse; -1 if it never comes.
    // On instance a, cycle inj presents clr_req plus a write to an already-swept entry.
    task automatic count_to_done(input int k, input int inj, output int n);
        bit got;
        got = 1'b0;
        n   = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            if ((k == 0) ? a.clr_done : b.clr_done) begin
                got = 1'b1;
            end else begin
                tick();
                n++;
                a.clr_req = 1'b0;
                a.we      = 1'b0;
                if (k == 0 && n == inj) begin
                    a.clr_req = 1'b1;
                    a.we      = 1'b1;
                    a.waddr   = 5'd3;
                    a.wdata   = 32'h55;
                end
            end
        end
        if (!got) n = -1;
    endtask

    int n;
    int busy_a, done_a, busy_b, done_b;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        a.we = 0; a.waddr = 0; a.wdata = 0; a.raddr1 = 0; a.raddr2 = 0; a.clr_req = 0;
        b.we = 0; b.waddr = 0; b.wdata = 0; b.raddr1 = 0; b.raddr2 = 0; b.clr_req = 0;

        // T1 / T6 sweep length: one reset cycle, then count busy and done cycles.
        tick();
        rst_a = 1'b0; rst_b = 1'b0;
        busy_a = 0; done_a = 0; busy_b = 0; done_b = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            busy_a += int'(a.clr_busy); done_a += int'(a.clr_done);
            busy_b += int'(b.clr_busy); done_b += int'(b.clr_done);
            tick();
        end
        chk("t1_busy_cycles", busy_a, 32);
        chk("t1_done_pulses", done_a, 1);
        chk("t6_busy_cycles", busy_b, 8);
        chk("t6_done_pulses", done_b, 1);
        for (int i = 0; i < 32; i++) begin
            a.raddr1 = 5'(i); a.raddr2 = 5'(31 - i);
            @(negedge clk);
            chk("t1_rd1_zero", a.rdata1, 32'h0);
            chk("t1_rd2_zero", a.rdata2, 32'h0);
            tick();
        end

        // T2: write then read back; entry 0 ignores writes.
        a.we = 1; a.waddr = 5; a.wdata = 32'hDEADBEEF;
        tick();
        a.we = 0; a.raddr1 = 5;
        @(negedge clk);
        chk("t2_rd_5", a.rdata1, 32'hDEADBEEF);
        tick();
        a.we = 1; a.waddr = 0; a.wdata = 32'hFFFFFFFF;
        tick();
        a.we = 0; a.raddr2 = 0;
        @(negedge clk);
        chk("t2_rd_0", a.rdata2, 32'h0);
        tick();

        // T3: clr_req beats a same-cycle write; writes and clr_req during the sweep are dropped.
        a.we = 1; a.waddr = 7; a.wdata = 32'h1234;
        tick();
        a.we = 1; a.waddr = 9; a.wdata = 32'hFF; a.clr_req = 1; a.raddr1 = 7;
        @(negedge clk);
        chk("t3_rd_7_before", a.rdata1, 32'h1234);
        tick();
        a.we = 0; a.clr_req = 0;
        count_to_done(0, 10, n);
        chk("t3_sweep_len", n, 32);
        tick();
        a.raddr1 = 7; a.raddr2 = 9;
        @(negedge clk);
        chk("t3_rd_7", a.rdata1, 32'h0);
        chk("t3_rd_9", a.rdata2, 32'h0);
        tick();
        a.raddr1 = 3; a.raddr2 = 5;
        @(negedge clk);
        chk("t3_rd_3_dropped", a.rdata1, 32'h0);
        chk("t3_rd_5_cleared", a.rdata2, 32'h0);
        tick();

        // T4: rst at ptr 17, held 3 cycles; the sweep restarts from 0.
        a.clr_req = 1;
        tick();
        a.clr_req = 0;
        repeat (17) tick();
        rst_a = 1;
        repeat (3) tick();
        rst_a = 0;
        count_to_done(0, -1, n);
        chk("t4_restart_len", n, 32);
        tick();

        // T5: same-cycle read of the entry being written.
        a.we = 1; a.waddr = 3; a.wdata = 32'h11111111;
        tick();
        a.we = 1; a.waddr = 3; a.wdata = 32'hA5A5A5A5; a.raddr1 = 3;
        @(negedge clk);
`ifdef REGFILE_BYPASS_EN
        chk("t5_same_cycle", a.rdata1, 32'hA5A5A5A5);
`else
        chk("t5_same_cycle", a.rdata1, 32'h11111111);
`endif
        tick();
        a.we = 0;
        @(negedge clk);
        chk("t5_next_cycle", a.rdata1, 32'hA5A5A5A5);
        tick();
        a.we = 1; a.waddr = 0; a.wdata = 32'h77; a.raddr2 = 0;
        @(negedge clk);
        chk("t5_zero_no_fwd", a.rdata2, 32'h0);
        tick();
        a.we = 0;

        // T6: entry 0 is ordinary on the narrow instance.
        b.we = 1; b.waddr = 0; b.wdata = 8'h3C; b.raddr1 = 0;
        @(negedge clk);
`ifdef REGFILE_BYPASS_EN
        chk("t6_rd0_same", 32'(b.rdata1), 32'h3C);
`else
        chk("t6_rd0_same", 32'(b.rdata1), 32'h0);
`endif
        tick();
        b.we = 1; b.waddr = 5; b.wdata = 8'h81;
        tick();
        b.we = 0; b.raddr2 = 5;
        @(negedge clk);
        chk("t6_rd0", 32'(b.rdata1), 32'h3C);
        chk("t6_rd5", 32'(b.rdata2), 32'h81);
        tick();
        b.clr_req = 1;
        tick();
        b.clr_req = 0;
        count_to_done(1, -1, n);
        chk("t6_sweep_len", n, 8);
        tick();
        @(negedge clk);
        chk("t6_rd0_cleared", 32'(b.rdata1), 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
